// File: rtl/pcap_replay_arbiter_pkg.sv
// Shared constants and types for the four-queue pcap replay arbiter.
package pcap_replay_arbiter_pkg;
  localparam int NUM_QUEUES = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef logic [1:0] qidx_t;
endpackage

// File: rtl/pcap_replay_arbiter_rr_grant_sel.sv
// Round-robin request search: first set req bit after 'last', wrapping modulo 4.
module rr_grant_sel
  import pcap_replay_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       hit,
  output logic [1:0] idx
);

  qidx_t cand;

  // i = NUM_QUEUES wraps back onto 'last', so it is searched with lowest priority.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      cand = last + qidx_t'(i);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/pcap_replay_arbiter.sv
// Packet-granular round-robin merge of four replay AXI-S queues onto one master,
// with per-queue forwarded-packet counters.
//
//   state | meaning
//   IDLE  | no grant held; pick next enabled, valid queue (1-cycle bubble)
//   SEND  | granted queue wired through to m_axis until its tlast handshake
module pcap_replay_arbiter
  import pcap_replay_arbiter_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s2_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s2_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s2_axis_tuser,
  input  logic                            s2_axis_tvalid,
  input  logic                            s2_axis_tlast,
  output logic                            s2_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s3_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s3_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s3_axis_tuser,
  input  logic                            s3_axis_tvalid,
  input  logic                            s3_axis_tlast,
  output logic                            s3_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [3:0]                      queue_en,
  input  logic                            cnt_clear,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_0,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_1,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_2,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_3,
  output logic                            busy
);

  logic [C_AXIS_DATA_WIDTH-1:0]   s_tdata [NUM_QUEUES];
  logic [C_AXIS_DATA_WIDTH/8-1:0] s_tkeep [NUM_QUEUES];
  logic [C_AXIS_TUSER_WIDTH-1:0]  s_tuser [NUM_QUEUES];
  logic [3:0]                     s_tvalid, s_tlast, s_tready;

  logic [0:0]           state_q, state_d;
  qidx_t                grant_q, grant_d, last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] pkt_cnt_d [NUM_QUEUES];

  logic  send, hit, xfer_last;
  qidx_t hit_idx;

  assign s_tdata[0] = s0_axis_tdata;
  assign s_tdata[1] = s1_axis_tdata;
  assign s_tdata[2] = s2_axis_tdata;
  assign s_tdata[3] = s3_axis_tdata;
  assign s_tkeep[0] = s0_axis_tkeep;
  assign s_tkeep[1] = s1_axis_tkeep;
  assign s_tkeep[2] = s2_axis_tkeep;
  assign s_tkeep[3] = s3_axis_tkeep;
  assign s_tuser[0] = s0_axis_tuser;
  assign s_tuser[1] = s1_axis_tuser;
  assign s_tuser[2] = s2_axis_tuser;
  assign s_tuser[3] = s3_axis_tuser;
  assign s_tvalid   = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
  assign s_tlast    = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};

  assign {s3_axis_tready, s2_axis_tready, s1_axis_tready, s0_axis_tready} = s_tready;

  assign send = (state_q == ST_SEND);
  assign busy = send;

  rr_grant_sel u_rr_grant_sel (
    .req  (s_tvalid & queue_en),
    .last (last_grant_q),
    .hit  (hit),
    .idx  (hit_idx)
  );

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_tready      = '0;
    if (send) begin
      m_axis_tdata      = s_tdata[grant_q];
      m_axis_tkeep      = s_tkeep[grant_q];
      m_axis_tuser      = s_tuser[grant_q];
      m_axis_tvalid     = s_tvalid[grant_q];
      m_axis_tlast      = s_tlast[grant_q];
      s_tready[grant_q] = m_axis_tready;
    end
  end

  assign xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // queue_en is only consulted at arbitration, so disabling a granted queue lets its packet finish.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_QUEUES; i++) pkt_cnt_d[i] = pkt_cnt_q[i];
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_SEND;
          grant_d = hit_idx;
        end
      end
      ST_SEND: begin
        if (xfer_last) begin
          state_d            = ST_IDLE;
          last_grant_d       = grant_q;
          pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cnt_clear) begin
      for (int i = 0; i < NUM_QUEUES; i++) pkt_cnt_d[i] = '0;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      for (int i = 0; i < NUM_QUEUES; i++) pkt_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NUM_QUEUES; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  assign pkt_cnt_0 = pkt_cnt_q[0];
  assign pkt_cnt_1 = pkt_cnt_q[1];
  assign pkt_cnt_2 = pkt_cnt_q[2];
  assign pkt_cnt_3 = pkt_cnt_q[3];

endmodule

// File: tb/tb_pcap_replay_arbiter.sv
// Directed bench for pcap_replay_arbiter: per-queue packet sources, an output
// monitor checking beat integrity and grant order, and hand-computed checks.
module tb_pcap_replay_arbiter;

  localparam int DW = 32;
  localparam int UW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]   sd [4];
  logic [DW/8-1:0] sk [4];
  logic [UW-1:0]   su [4];
  logic [3:0]      sv, sl, sready;
  logic [DW-1:0]   m_tdata;
  logic [DW/8-1:0] m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid, m_tlast, mready;
  logic [3:0]      queue_en;
  logic            cnt_clear;
  logic [CW-1:0]   cnt0, cnt1, cnt2, cnt3;
  logic            busy;

  int tests = 0;
  int fails = 0;

  int len [4];
  int npk [4];
  int src_pkt [4];
  int src_beat [4];
  logic [3:0] hs_s;

  int mon_pkt [4];
  int mon_beat [4];
  int beats = 0;
  int order_q [$];
  int mq;
  logic [DW-1:0] exp_d;
  logic exp_last;

  pcap_replay_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .CNT_WIDTH         (CW)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .s0_axis_tdata (sd[0]), .s0_axis_tkeep(sk[0]), .s0_axis_tuser(su[0]),
    .s0_axis_tvalid(sv[0]), .s0_axis_tlast(sl[0]), .s0_axis_tready(sready[0]),
    .s1_axis_tdata (sd[1]), .s1_axis_tkeep(sk[1]), .s1_axis_tuser(su[1]),
    .s1_axis_tvalid(sv[1]), .s1_axis_tlast(sl[1]), .s1_axis_tready(sready[1]),
    .s2_axis_tdata (sd[2]), .s2_axis_tkeep(sk[2]), .s2_axis_tuser(su[2]),
    .s2_axis_tvalid(sv[2]), .s2_axis_tlast(sl[2]), .s2_axis_tready(sready[2]),
    .s3_axis_tdata (sd[3]), .s3_axis_tkeep(sk[3]), .s3_axis_tuser(su[3]),
    .s3_axis_tvalid(sv[3]), .s3_axis_tlast(sl[3]), .s3_axis_tready(sready[3]),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (mready),
    .queue_en      (queue_en),
    .cnt_clear     (cnt_clear),
    .pkt_cnt_0     (cnt0),
    .pkt_cnt_1     (cnt1),
    .pkt_cnt_2     (cnt2),
    .pkt_cnt_3     (cnt3),
    .busy          (busy)
  );

  // Source queue q sends npk[q] packets of len[q] beats; data encodes {q, pkt, 0, beat}.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      sd[q] = {8'(q), 8'(src_pkt[q]), 8'h00, 8'(src_beat[q])};
      sk[q] = 4'(q + 1);
      su[q] = {8'(q), 8'(src_beat[q])};
      sv[q] = (src_pkt[q] < npk[q]);
      sl[q] = (src_beat[q] == len[q] - 1);
    end
  end

  always @(negedge clk) hs_s = sready & sv;

  always begin
    @(posedge clk);
    #1;
    for (int q = 0; q < 4; q++) begin
      if (rst) src_beat[q] = 0;
      else if (hs_s[q]) begin
        if (src_beat[q] == len[q] - 1) begin
          src_beat[q] = 0;
          src_pkt[q]  = src_pkt[q] + 1;
        end else src_beat[q] = src_beat[q] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int q = 0; q < 4; q++) mon_beat[q] = 0;
    end else begin
      if (!busy) begin
        tests++;
        assert (m_tvalid === 1'b0 && sready === 4'b0 && m_tdata === '0 && m_tlast === 1'b0)
        else begin
          fails++;
          $error("FAIL idle_outputs: got valid=%b ready=%b data=%h last=%b, expected all 0",
                 m_tvalid, sready, m_tdata, m_tlast);
        end
      end
      if (m_tvalid && mready) begin
        mq       = int'(m_tdata[25:24]);
        exp_d    = {8'(mq), 8'(mon_pkt[mq]), 8'h00, 8'(mon_beat[mq])};
        exp_last = (mon_beat[mq] == len[mq] - 1);
        tests++;
        assert (m_tdata === exp_d && m_tlast === exp_last && sready === 4'(1 << mq) &&
                m_tkeep === 4'(mq + 1) && m_tuser === {8'(mq), 8'(mon_beat[mq])})
        else begin
          fails++;
          $error("FAIL beat: got data=%h last=%b ready=%b keep=%h user=%h, expected data=%h last=%b",
                 m_tdata, m_tlast, sready, m_tkeep, m_tuser, exp_d, exp_last);
        end
        beats++;
        if (exp_last) begin
          mon_beat[mq] = 0;
          mon_pkt[mq]  = mon_pkt[mq] + 1;
          order_q.push_back(mq);
        end else mon_beat[mq] = mon_beat[mq] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (order_q.size() < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(order_q.size()), 64'(target));
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(busy), 64'd1);
  endtask

  int base, bbase, idle_cnt, n;
  int exp_order [8];

  initial begin
    for (int q = 0; q < 4; q++) begin
      len[q] = 1; npk[q] = 0; src_pkt[q] = 0; src_beat[q] = 0;
      mon_pkt[q] = 0; mon_beat[q] = 0;
    end
    rst = 1'b1; queue_en = 4'h0; mready = 1'b0; cnt_clear = 1'b0;

    // reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_ready", 64'(sready), 64'd0);
    chk("rst_cnt", 64'({cnt0, cnt1, cnt2, cnt3}), 64'd0);
    step();
    rst = 1'b0;

    // single 3-beat packet from queue 0
    step();
    len[0] = 3; npk[0] = 1; queue_en = 4'hF; mready = 1'b1;
    @(negedge clk); #1;
    chk("bubble_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("first_busy", 64'(busy), 64'd1);
    chk("first_data", 64'(m_tdata), 64'h0000_0000);
    chk("first_ready", 64'(sready), 64'b0001);
    wait_done(1, 20, "pkt0_done");
    step(); step();
    chk("cnt0_one", 64'(cnt0), 64'd1);
    chk("cnt_others", 64'({cnt1, cnt2, cnt3}), 64'd0);

    // reset clears counters and restores queue 0 priority; then 4-way round robin
    #2 rst = 1'b1;
    #1 chk("rst2_cnt0", 64'(cnt0), 64'd0);
    step();
    rst = 1'b0;
    step();
    for (int q = 0; q < 4; q++) begin
      len[q] = 2; npk[q] = npk[q] + 2;
    end
    base = order_q.size();
    wait_busy(10, "rr_start");
    idle_cnt = 0; n = 0;
    while (order_q.size() < base + 8 && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (!busy) idle_cnt++;
    end
    chk("rr_done", 64'(order_q.size()), 64'(base + 8));
    chk("rr_idle_bubbles", 64'(idle_cnt), 64'd7);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(order_q[base + i]), 64'(exp_order[i]));
    step(); step();
    chk("rr_cnts", 64'({cnt0, cnt1, cnt2, cnt3}), 64'h2222);

    // cnt_clear, then only queues 1 and 3 enabled
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clear_cnts", 64'({cnt0, cnt1, cnt2, cnt3}), 64'd0);
    queue_en = 4'b1010;
    for (int q = 0; q < 4; q++) npk[q] = npk[q] + 2;
    base = order_q.size();
    wait_done(base + 4, 60, "mask_done");
    exp_order = '{1, 3, 1, 3, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) chk("mask_order", 64'(order_q[base + i]), 64'(exp_order[i]));
    step(); step();
    chk("mask_cnts", 64'({cnt0, cnt1, cnt2, cnt3}), 64'h0202);
    queue_en = 4'hF;
    wait_done(base + 8, 60, "drain_done");
    chk("drain_first", 64'(order_q[base + 4]), 64'd0);
    step(); step();

    // 4-beat queue 2 packet under ready toggling, enable dropped after first beat
    len[2] = 4; npk[2] = npk[2] + 1;
    base = order_q.size(); bbase = beats;
    n = 0;
    while (order_q.size() < base + 1 && n < 60) begin
      step();
      mready = ~mready;
      if (beats - bbase >= 1) queue_en[2] = 1'b0;
      n++;
    end
    chk("toggle_done", 64'(order_q.size()), 64'(base + 1));
    chk("toggle_beats", 64'(beats - bbase), 64'd4);
    chk("toggle_queue", 64'(order_q[base]), 64'd2);
    mready = 1'b1;
    step(); step();
    chk("toggle_cnt2", 64'(cnt2), 64'd3);
    queue_en = 4'hF;

    // counter wrap on queue 1
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    len[1] = 1; npk[1] = npk[1] + 15;
    base = order_q.size();
    wait_done(base + 15, 100, "wrap_fill");
    step(); step();
    chk("cnt1_full", 64'(cnt1), 64'hF);
    npk[1] = npk[1] + 1;
    wait_done(base + 16, 20, "wrap_last");
    step(); step();
    chk("cnt1_wrap", 64'(cnt1), 64'd0);

    // cnt_clear coincident with a tlast handshake on queue 3
    mready = 1'b0; len[3] = 1; npk[3] = npk[3] + 1;
    wait_busy(10, "coinc_busy");
    step();
    mready = 1'b1; cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    @(negedge clk); #1;
    chk("coinc_cnt3", 64'(cnt3), 64'd0);
    chk("coinc_idle", 64'(busy), 64'd0);

    // asynchronous reset mid-packet, then a 4-way tie
    len[0] = 4; npk[0] = npk[0] + 1;
    wait_busy(10, "mid_busy");
    bbase = beats;
    n = 0;
    while (beats - bbase < 1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_mvalid", 64'(m_tvalid), 64'd0);
    chk("async_ready", 64'(sready), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_cnt0", 64'(cnt0), 64'd0);
    step(); step();
    rst = 1'b0;
    for (int q = 0; q < 4; q++) begin
      len[q] = 2; npk[q] = npk[q] + 1;
    end
    base = order_q.size();
    wait_done(base + 5, 60, "tie_done");
    chk("tie_first", 64'(order_q[base]), 64'd0);
    chk("tie_second", 64'(order_q[base + 1]), 64'd1);
    step(); step();
    chk("tie_cnt0", 64'(cnt0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcap_replay_arbiter.md
PCAP_REPLAY_ARBITER -- requirements
Module: pcap_replay_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, tdata width of all ports.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of all ports.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, per-queue packet counter width.
REQ-004 SHALL have port axis_aclk, input, 1, the single clock for all logic.
REQ-005 SHALL have port axis_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports sN_axis_tdata/tkeep/tuser/tvalid/tlast, inputs, DATA/DATA/8/TUSER/1/1, for N=0..3: AXI-S slaves carrying replayed packets from the four external-memory queues.
REQ-007 SHALL have ports sN_axis_tready, output, 1, N=0..3.
REQ-008 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast, outputs, DATA/DATA/8/TUSER/1/1: merged AXI-S master.
REQ-009 SHALL have port m_axis_tready, input, 1.
REQ-010 SHALL have port queue_en, input, 4, per-queue arbitration enable (bit N = queue N).
REQ-011 SHALL have port cnt_clear, input, 1, synchronous clear of all packet counters.
REQ-012 SHALL have ports pkt_cnt_N, output, CNT_WIDTH, N=0..3: packets forwarded from queue N.
REQ-013 SHALL have port busy, output, 1, high while a packet is being forwarded.

Function
REQ-014 SHALL implement FSM states IDLE and SEND; arbitration is packet-granular, never switching queue mid-packet.
REQ-015 In IDLE, SHALL select the first queue N with sN_axis_tvalid & queue_en[N], searching round-robin from last_grant+1 modulo 4; on a hit register grant=N, move to SEND next cycle (1-cycle arbitration bubble).
REQ-016 In IDLE, all sN_axis_tready and m_axis_tvalid SHALL be 0.
REQ-017 In SEND, m_axis_* SHALL combinationally equal the granted queue's tdata/tkeep/tuser/tvalid/tlast; sGRANT_axis_tready = m_axis_tready; other sN_axis_tready = 0; non-granted data never reaches m_axis.
REQ-018 In SEND, on m_axis_tvalid & m_axis_tready & m_axis_tlast SHALL set last_grant=grant, return to IDLE, and increment pkt_cnt_grant by 1.
REQ-019 Outside SEND, m_axis_tdata/tkeep/tuser/tlast SHALL be driven 0.
REQ-020 Deasserting queue_en[grant] during SEND SHALL NOT abort the packet; it only excludes the queue from the next arbitration.
REQ-021 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0; cnt_clear coincident with an increment SHALL yield 0.
REQ-022 busy SHALL be 1 exactly when state is SEND.
REQ-023 tvalid from a granted queue dropping mid-packet SHALL hold SEND with m_axis_tvalid=0 (no timeout).

Reset
REQ-024 On axis_reset assertion, state SHALL become IDLE, all tready/tvalid/tlast and m_axis data outputs 0, all pkt_cnt_N 0, busy 0, last_grant=3 (queue 0 first priority), asynchronously, without waiting for a clock edge.
REQ-025 Reset mid-packet SHALL discard the in-flight packet state; the partially sent packet is not counted.

Structure
REQ-026 A shared package SHALL hold NUM_QUEUES=4, state encodings (IDLE=0, SEND=1) and the 2-bit queue index type.
REQ-027 Round-robin next-grant search SHALL be a sub-module rr_grant_sel (inputs req[3:0], last[1:0]; outputs hit, idx[1:0]), combinational.

Verification
REQ-028 After reset, s0 sends 3-beat packet, m_axis_tready=1, queue_en=4'hF -> packet appears on m_axis starting cycle 2, pkt_cnt_0=1, s1..s3 tready stay 0.
REQ-029 All four queues valid continuously, 2-beat packets -> grant order 0,1,2,3,0 with one idle cycle between packets; each pkt_cnt_N=2 after 8 packets.
REQ-030 queue_en=4'b1010, all queues valid -> only queues 1 and 3 forwarded, alternating; pkt_cnt_0=pkt_cnt_2=0.
REQ-031 During a 4-beat s2 packet, m_axis_tready toggled 1,0,1,0,... and queue_en[2] cleared after beat 1 -> all 4 beats delivered intact, no beat duplicated or dropped, pkt_cnt_2 increments once.
REQ-032 Force pkt_cnt_1=32'hFFFFFFFF by preload, forward one s1 packet -> pkt_cnt_1=0; cnt_clear on same cycle as a tlast handshake -> counter 0.
REQ-033 axis_reset asserted mid-packet between clock edges -> m_axis_tvalid and all tready drop to 0 before next edge; after release queue 0 wins a 4-way tie.
